// File: rtl/vend_pkg.sv
// Shared definitions for the vending transaction controller: states, coin
// codes, error codes and the money width.
package vend_pkg;

  localparam int MONEY_W = 16;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_COLLECT  = 3'd1,
    ST_CHECK    = 3'd2,
    ST_DISPENSE = 3'd3,
    ST_WAIT_ACK = 3'd4,
    ST_CHANGE   = 3'd5
  } vend_state_e;

  localparam logic [1:0] COIN_5  = 2'b00;
  localparam logic [1:0] COIN_10 = 2'b01;
  localparam logic [1:0] COIN_20 = 2'b10;
  localparam logic [1:0] COIN_50 = 2'b11;

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_STOCK   = 2'b01;
  localparam logic [1:0] ERR_FUNDS   = 2'b10;
  localparam logic [1:0] ERR_TIMEOUT = 2'b11;

  // Money value of a coin code, in price units.
  function automatic logic [MONEY_W-1:0] coin_value(input logic [1:0] code);
    logic [MONEY_W-1:0] v;
    case (code)
      COIN_5:  v = 16'd5;
      COIN_10: v = 16'd10;
      COIN_20: v = 16'd20;
      default: v = 16'd50;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/vend_timeout_timer.sv
// Saturating inactivity counter: clear has priority, counts while enabled,
// expired once the count reaches LIMIT.
module vend_timeout_timer #(
  parameter int W     = 8,
  parameter int LIMIT = 255
) (
  input  logic CLK,
  input  logic RESET,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  logic [W-1:0] count_reg;

  // Count idle cycles, holding at all-ones so the counter never wraps.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      count_reg <= '0;
    end else if (clear) begin
      count_reg <= '0;
    end else if (enable && (count_reg != '1)) begin
      count_reg <= count_reg + W'(1);
    end
  end

  assign expired = (count_reg >= W'(LIMIT));

endmodule

// File: rtl/vend_transaction_controller.sv
// One vending transaction: collect credit, latch a selection, check stock
// and funds, pulse buy once per unit with an ack in between, return change.
module vend_transaction_controller
  import vend_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int MAX_CREDIT     = 500,
  parameter int MAX_QTY        = 10
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic               coin_valid,
  input  logic [1:0]         coin_code,
  input  logic               select_valid,
  input  logic [2:0]         select_id,
  input  logic [3:0]         select_qty,
  input  logic               cancel,
  input  logic [4:0]         stock_amount,
  input  logic [7:0]         unit_price,
  input  logic               dispense_ack,
  output logic [2:0]         product_id,
  output logic               buy_pulse,
  output logic [MONEY_W-1:0] credit,
  output logic               change_valid,
  output logic [MONEY_W-1:0] change_amount,
  output logic               coin_reject,
  output logic [1:0]         err_code,
  output logic [2:0]         state
);

  localparam int TW = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;

  vend_state_e        state_reg, state_next;
  logic [MONEY_W-1:0] credit_reg, credit_next;
  logic [2:0]         pid_reg, pid_next;
  logic [3:0]         qty_reg, qty_next;
  logic [3:0]         remaining_reg, remaining_next;
  logic [1:0]         err_reg, err_next;
  logic               coin_reject_reg, coin_reject_next;
  logic               activity;
  logic               expired;
  logic               timer_clear;

  // Coin arithmetic one bit wider so the ceiling compare cannot wrap.
  logic [MONEY_W:0]   coin_sum;
  logic               coin_over;
  logic [11:0]        cost;
  logic [4:0]         rem_plus;
  logic [MONEY_W-1:0] refund;
  logic               sel_ok;

  assign coin_sum  = {1'b0, credit_reg} + {1'b0, coin_value(coin_code)};
  assign coin_over = coin_sum > (MONEY_W+1)'(MAX_CREDIT);
  assign cost      = {4'b0, unit_price} * {8'b0, qty_reg};
  // The unit in flight when the mechanism stalls is refunded too.
  assign rem_plus  = {1'b0, remaining_reg} + 5'd1;
  assign refund    = {8'b0, unit_price} * {11'b0, rem_plus};
  assign sel_ok    = select_valid && (select_qty != 4'd0) && (select_qty <= 4'(MAX_QTY));

  // Timer restarts on every state change or front-panel activity.
  assign timer_clear = (state_next != state_reg) || activity;

  vend_timeout_timer #(
    .W     (TW),
    .LIMIT (TIMEOUT_CYCLES)
  ) u_timer (
    .CLK     (CLK),
    .RESET   (RESET),
    .clear   (timer_clear),
    .enable  ((state_reg == ST_COLLECT) || (state_reg == ST_WAIT_ACK)),
    .expired (expired)
  );

  // State and datapath registers; reset discards credit silently.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_reg       <= ST_IDLE;
      credit_reg      <= '0;
      pid_reg         <= '0;
      qty_reg         <= '0;
      remaining_reg   <= '0;
      err_reg         <= ERR_NONE;
      coin_reject_reg <= 1'b0;
    end else begin
      state_reg       <= state_next;
      credit_reg      <= credit_next;
      pid_reg         <= pid_next;
      qty_reg         <= qty_next;
      remaining_reg   <= remaining_next;
      err_reg         <= err_next;
      coin_reject_reg <= coin_reject_next;
    end
  end

  // Next-state and datapath update for the transaction sequence.
  always_comb begin
    state_next       = state_reg;
    credit_next      = credit_reg;
    pid_next         = pid_reg;
    qty_next         = qty_reg;
    remaining_next   = remaining_reg;
    err_next         = err_reg;
    coin_reject_next = 1'b0;
    activity         = 1'b0;

    // A fresh coin or selection clears a stale error; errors raised below win.
    if (coin_valid || select_valid) err_next = ERR_NONE;

    case (state_reg)
      ST_IDLE: begin
        if (coin_valid) begin
          if (coin_over) begin
            coin_reject_next = 1'b1;
          end else begin
            credit_next = coin_sum[MONEY_W-1:0];
            state_next  = ST_COLLECT;
          end
        end
      end
      ST_COLLECT: begin
        activity = coin_valid || select_valid;
        if (coin_valid) begin
          if (coin_over) coin_reject_next = 1'b1;
          else           credit_next = coin_sum[MONEY_W-1:0];
        end
        if (cancel) begin
          state_next = ST_CHANGE;
        end else if (sel_ok) begin
          pid_next   = select_id;
          qty_next   = select_qty;
          state_next = ST_CHECK;
        end else if (expired && !activity) begin
          err_next   = ERR_TIMEOUT;
          state_next = ST_CHANGE;
        end
      end
      ST_CHECK: begin
        if (stock_amount < {1'b0, qty_reg}) begin
          err_next   = ERR_STOCK;
          state_next = ST_COLLECT;
        end else if (credit_reg < {4'b0, cost}) begin
          err_next   = ERR_FUNDS;
          state_next = ST_COLLECT;
        end else begin
          credit_next    = credit_reg - {4'b0, cost};
          remaining_next = qty_reg;
          state_next     = ST_DISPENSE;
        end
      end
      ST_DISPENSE: begin
        remaining_next = remaining_reg - 4'd1;
        state_next     = ST_WAIT_ACK;
      end
      ST_WAIT_ACK: begin
        if (dispense_ack) begin
          state_next = (remaining_reg != 4'd0) ? ST_DISPENSE : ST_CHANGE;
        end else if (expired) begin
          credit_next = credit_reg + refund;
          err_next    = ERR_TIMEOUT;
          state_next  = ST_CHANGE;
        end
      end
      ST_CHANGE: begin
        credit_next = '0;
        state_next  = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase

    if (coin_valid && (state_reg != ST_IDLE) && (state_reg != ST_COLLECT)) begin
      coin_reject_next = 1'b1;
    end
  end

  assign product_id    = pid_reg;
  assign buy_pulse     = (state_reg == ST_DISPENSE);
  assign credit        = credit_reg;
  assign change_valid  = (state_reg == ST_CHANGE);
  assign change_amount = (state_reg == ST_CHANGE) ? credit_reg : '0;
  assign coin_reject   = coin_reject_reg;
  assign err_code      = err_reg;
  assign state         = state_reg;

endmodule

// File: doc/vend_transaction_controller.md
Name: vend_transaction_controller

Overview:
- Sequences one vending transaction end to end: accumulates inserted credit, latches a product selection, checks stock and funds, then issues one buy pulse per unit to the product manager and returns change.
- Sits between the front-panel inputs and the money counter / product manager datapath.
- Replaces free-running per-cycle enables with a registered, handshaked control flow.
- Money is in units of 100; coin values are 5/10/20/50, the same units as product prices.

Parameters:
- TIMEOUT_CYCLES, 255: idle cycles allowed in COLLECT or WAIT_ACK before auto-abort.
- MAX_CREDIT, 500: credit ceiling; a coin that would exceed it is rejected.
- MAX_QTY, 10: largest quantity accepted per transaction.

Ports:
- CLK  in  1  clock
- RESET  in  1  asynchronous active-high reset
- coin_valid  in  1  one-cycle coin strobe
- coin_code  in  2  00=5, 01=10, 10=20, 11=50
- select_valid  in  1  one-cycle selection strobe
- select_id  in  3  product index
- select_qty  in  4  requested units
- cancel  in  1  abort request
- stock_amount  in  5  stock of product_id (combinational from product manager)
- unit_price  in  8  price of product_id (combinational from product manager)
- dispense_ack  in  1  mechanism finished one unit
- product_id  out  3  latched selection, drives product manager
- buy_pulse  out  1  one-cycle didBuy per unit
- credit  out  16  current credit
- change_valid  out  1  one-cycle strobe with change_amount
- change_amount  out  16  credit refunded or returned
- coin_reject  out  1  one-cycle; coin refused
- err_code  out  2  00 none, 01 out-of-stock, 10 insufficient funds, 11 timeout; held until next select_valid or coin
- state  out  3  current state, for the display block

Behaviour:
- Clock and reset: CLK, RESET asynchronous active-high.
  - All registers reset to zero; state=IDLE; product_id=0.
  - A reset mid-transaction discards credit with no change_valid.
- States: IDLE=0, COLLECT=1, CHECK=2, DISPENSE=3, WAIT_ACK=4, CHANGE=5.
- IDLE:
  - coin_valid: credit+=value, go to COLLECT next cycle.
  - select_valid with credit==0: ignored.
- COLLECT:
  - coin_valid adds value.
  - If credit+value>MAX_CREDIT: coin_reject=1 and credit unchanged.
  - select_valid with select_qty in 1..MAX_QTY: latch id and qty, go to CHECK. qty 0 or >MAX_QTY is ignored.
  - cancel, or the timeout counter reaching TIMEOUT_CYCLES with no coin/select activity: go to CHANGE with the full credit. A timeout also sets err_code=11.
- CHECK (one cycle, using stock_amount/unit_price for the latched id):
  - cost = unit_price*qty, 12-bit product zero-extended to 16.
  - stock_amount<qty: err_code=01, back to COLLECT, credit kept.
  - credit<cost: err_code=10, back to COLLECT.
  - Otherwise: credit-=cost, remaining=qty, go to DISPENSE.
- DISPENSE: buy_pulse=1 for exactly one cycle, remaining-=1, go to WAIT_ACK.
- WAIT_ACK:
  - dispense_ack: if remaining>0 go to DISPENSE, else go to CHANGE.
  - Timeout: refund credit + unit_price*(remaining+1) in CHANGE, err_code=11.
  - cancel is ignored once dispensing has started.
- CHANGE:
  - change_valid=1 and change_amount=credit for one cycle.
  - credit cleared, go to IDLE.
  - If credit==0, change_valid still pulses with amount 0.
- Simultaneous events:
  - coin_valid and select_valid in the same COLLECT cycle: the coin is added first and the selection is evaluated in CHECK against the updated credit.
  - cancel wins over select_valid.
  - coin_valid outside IDLE/COLLECT: coin_reject=1.
- Timeout counter: 8+ bits, cleared on any state change or accepted input; saturates.
- buy_pulse never asserts twice without an intervening dispense_ack.

Decomposition:
- Shared package vend_pkg holds:
  - state encodings
  - coin code values and the coin_value function
  - err_code constants
  - MONEY_W=16
- One natural sub-module, vend_timeout_timer: counter with clear, enable and expired output, instantiated once.

Test Plan:
- Coins 50,20 then select id=1 qty=2, price 15 -> CHECK passes; credit 70 becomes 40; two buy_pulses, each after an ack; change_valid with 40; return to IDLE.
- Coin 10, select price 25 qty 1 -> err_code=10, state returns to COLLECT, credit stays 10; cancel -> change_amount=10.
- stock_amount=1, select qty 3 with enough credit -> err_code=01, no buy_pulse, credit unchanged.
- Credit 480, insert 50 -> coin_reject pulses, credit stays 480.
- Coin 5, then no activity for TIMEOUT_CYCLES -> err_code=11, change_amount=5.
- RESET asserted in WAIT_ACK with credit 30 -> IDLE immediately, credit=0, no change_valid.
